// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the sequencer state encoding, default vectors and the alignment mask.
package pc_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

    // Redirect targets must be word aligned; any bit set here is a misalignment.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_adder.sv
// Parametrised combinational adder used for pc + STEP and the branch target.
// Wraps modulo 2^WIDTH with no carry out.
module pc_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with prioritised next-PC selection, fetch handshake
// and halt/resume control for the fetch stage.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
    parameter int unsigned     OFF_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_off,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             exception,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             fetch_valid,
    output logic             addr_err
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             addr_err_q, addr_err_d;

    logic [WIDTH-1:0] off_sext;
    logic [WIDTH-1:0] off_bytes;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] redir_target;
    logic             redir_misaligned;

    pc_adder #(
        .WIDTH (WIDTH)
    ) u_step_adder (
        .a_i   (pc_q),
        .b_i   (WIDTH'(STEP)),
        .sum_o (pc_plus_step)
    );

    // Word offset is sign-extended to full width before scaling to bytes.
    assign off_sext  = {{(WIDTH - OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign off_bytes = {off_sext[WIDTH-3:0], 2'b00};

    pc_adder #(
        .WIDTH (WIDTH)
    ) u_branch_adder (
        .a_i   (pc_plus_step),
        .b_i   (off_bytes),
        .sum_o (br_target)
    );

    assign redir_target     = jump ? jump_addr : br_target;
    assign redir_misaligned = |(redir_target[1:0] & ALIGN_MASK);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (exception) begin
                    pc_d = EXC_VECTOR;
                end else if (jump || branch_taken) begin
                    if (redir_misaligned) begin
                        pc_d       = EXC_VECTOR;
                        addr_err_d = 1'b1;
                    end else begin
                        pc_d = redir_target;
                    end
                end else if (fetch_ready) begin
                    pc_d = pc_plus_step;
                end
                if (halt && !exception) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (exception) begin
                    pc_d    = EXC_VECTOR;
                    state_d = StRun;
                end else if (resume) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VECTOR;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == StRun);
    assign addr_err    = addr_err_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the processor fetch stage. It replaces the free-standing PC adder with a registered PC, a prioritised next-PC selector (exception, jump, branch, sequential), a fetch valid/ready handshake toward instruction memory, and halt/resume control. It sits between the control/branch unit and the instruction memory port.

## Interface
Parameters:
- WIDTH, 32, address width in bits.
- STEP, 4, sequential increment in bytes.
- RESET_VECTOR, 0, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on exception or misaligned redirect.
- OFF_W, 16, width of the signed branch word offset.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts the current pc.
- branch_taken  in  1  take a PC-relative branch this cycle.
- branch_off  in  OFF_W  signed word offset; target = pc + STEP + (sign_ext(branch_off) << 2).
- jump  in  1  absolute jump this cycle.
- jump_addr  in  WIDTH  absolute jump target.
- exception  in  1  vector to EXC_VECTOR.
- halt  in  1  stop fetching.
- resume  in  1  leave HALT.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus_step  out  WIDTH  pc + STEP, combinational from pc (link value).
- fetch_valid  out  1  pc is a valid fetch request.
- addr_err  out  1  one-cycle pulse: a misaligned redirect target was replaced by EXC_VECTOR.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT -> RUN unconditionally on the first clock edge after rst is deasserted.
- RUN -> HALT when halt=1 and there is no exception. HALT -> RUN on resume=1 or exception=1.
- fetch_valid = (state == RUN).
- Next-PC priority, evaluated every cycle in RUN, highest first:
  - exception: EXC_VECTOR.
  - jump: jump_addr.
  - branch_taken: branch target.
  - fetch_ready: pc + STEP.
  - otherwise: hold.
- Redirects (exception, jump, branch) are taken even when fetch_ready=0. The pending fetch is abandoned.
- Alignment: a jump or branch target with bits [1:0] != 0 loads EXC_VECTOR instead and pulses addr_err. EXC_VECTOR itself is never checked.
- In HALT: pc holds and jump/branch are ignored. An exception loads EXC_VECTOR and returns the block to RUN.
- In BOOT: all inputs are ignored and pc stays at RESET_VECTOR.
- Arithmetic is modulo 2^WIDTH. Both pc + STEP and the branch target wrap silently, with no flag. branch_off is sign-extended to WIDTH before the shift.

## Timing
- Reset values, asynchronous: pc = RESET_VECTOR, state = BOOT, fetch_valid = 0, addr_err = 0. pc_plus_step = RESET_VECTOR + STEP.
- The first valid fetch is presented one cycle after the first post-reset edge.
- A redirect sampled at edge N appears on pc after edge N. There is one cycle of latency and no delay slot inserted by this block.
- addr_err is registered and is high for exactly the cycle in which pc = EXC_VECTOR caused by misalignment.
- The handshake completes on an edge where fetch_valid & fetch_ready. pc and fetch_valid are stable while fetch_ready=0 unless a redirect arrives.
- Simultaneous events:
  - halt with jump/branch: the redirect is taken, then the block enters HALT.
  - halt with exception: EXC_VECTOR is loaded and the block stays in RUN.
- rst asserted mid-stream: the reset values take effect immediately, without waiting for a clock edge.

## Structure
- Shared package pc_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the default RESET_VECTOR and EXC_VECTOR;
  - the alignment mask constant.
- One sub-module, pc_adder: a parametrised WIDTH-bit combinational adder. It is instantiated twice, once for pc + STEP and once for the branch target.
- pc_sequencer holds the state register, the priority mux, the alignment check and the output registers.

## Test plan
- Reset/boot: with rst high, pc = 0 and fetch_valid = 0. Deassert rst → fetch_valid = 1 one cycle later. With fetch_ready=1, pc steps 0, 4, 8, 12.
- Back-pressure: at pc = 0x10, set fetch_ready=0 for 3 cycles → pc holds 0x10. Then raise fetch_ready → pc = 0x14.
- Branch and jump:
  - At pc = 0x100 with branch_off = -2 → pc = 0xFC.
  - jump_addr = 0x2000 together with branch_taken → pc = 0x2000 (jump wins).
- Exception priority and misalignment:
  - exception, jump and branch all high → pc = 0x80.
  - jump_addr = 0x2002 → pc = 0x80 and addr_err high for one cycle.
- Halt/resume:
  - halt at pc = 0x40 → fetch_valid = 0 and pc holds at 0x44.
  - A jump during HALT is ignored.
  - resume → fetch_valid = 1 with pc = 0x44.
  - exception during HALT → pc = 0x80, back in RUN.
- Wrap and async reset:
  - At pc = 0xFFFF_FFFC → pc = 0x0000_0000 next cycle.
  - Pulse rst between clock edges → pc = 0 immediately.
